// File: rtl/barrel_shifter_if.sv
// barrel_shifter_if: operand/result bundle for the barrel shifter
//   in_valid  : operand fields are valid this cycle
//   datain    : WIDTH-bit operand
//   shiftamt  : shift distance 0..WIDTH-1
//   shifttype : operation select
//   out_valid : dataout holds a new result this cycle
//   dataout   : registered result
interface barrel_shifter_if #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
);
    logic             in_valid;
    logic [WIDTH-1:0] datain;
    logic [SHW-1:0]   shiftamt;
    logic [2:0]       shifttype;
    logic             out_valid;
    logic [WIDTH-1:0] dataout;
    modport master (output in_valid, datain, shiftamt, shifttype, input out_valid, dataout);
    modport slave  (input in_valid, datain, shiftamt, shifttype, output out_valid, dataout);
endinterface

// File: rtl/barrel_shifter.sv
// barrel_shifter: logical/arithmetic/rotate shifter with one registered output stage
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : operand in (in_valid, datain, shiftamt, shifttype), result out (out_valid, dataout)
module barrel_shifter #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    barrel_shifter_if.slave  bus
);
    logic                      w_pass;
    logic                      w_left;
    logic                      w_rot;
    logic                      w_sign;
    logic [WIDTH-1:0]          w_rev_in;
    logic [WIDTH-1:0]          w_rev_out;
    logic [SHW:0][WIDTH-1:0]   w_stage;
    logic [WIDTH-1:0]          w_result;
    logic [WIDTH-1:0]          r_dataout;
    logic                      r_out_valid;
    assign w_pass = bus.shifttype[2] & bus.shifttype[1];
    assign w_left = ~bus.shifttype[0] & ~w_pass;
    assign w_rot  = bus.shifttype[2];
    // Sign fill only for ASR; left shifts run through the right-shift network bit-reversed.
    assign w_sign = (bus.shifttype == 3'b011) & bus.datain[WIDTH-1];
    for (genvar b = 0; b < WIDTH; b++) begin : g_rev
        assign w_rev_in[b]  = bus.datain[WIDTH-1-b];
        assign w_rev_out[b] = w_stage[SHW][WIDTH-1-b];
    end
    assign w_stage[0] = w_left ? w_rev_in : bus.datain;
    // Stage k shifts right by 2**k; vacated MSBs take wrapped LSBs (rotate) or the fill bit.
    for (genvar k = 0; k < SHW; k++) begin : g_stage
        localparam int D = 1 << k;
        assign w_stage[k+1] = bus.shiftamt[k]
            ? {(w_rot ? w_stage[k][D-1:0] : {D{w_sign}}), w_stage[k][WIDTH-1:D]}
            : w_stage[k];
    end
    assign w_result = w_pass ? bus.datain : (w_left ? w_rev_out : w_stage[SHW]);
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_dataout   <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= bus.in_valid;
            if (bus.in_valid) r_dataout <= w_result;
        end
    end
    assign bus.dataout   = r_dataout;
    assign bus.out_valid = r_out_valid;
endmodule

// File: tb/tb_barrel_shifter.sv
// tb_barrel_shifter: table, directed, exhaustive and random checks against a reference model
module tb_barrel_shifter;
    localparam int W = 8;
    localparam int S = 3;
    typedef struct {
        logic [W-1:0] d;
        logic [S-1:0] a;
        logic [2:0]   t;
        logic [W-1:0] e;
    } vec_t;
    logic         clk;
    logic         rst_n;
    int           checks;
    int           errors;
    logic         exp_valid;
    logic [W-1:0] exp_data;
    vec_t         tbl[$];
    barrel_shifter_if #(.WIDTH(W), .SHW(S)) bus ();
    barrel_shifter #(.WIDTH(W), .SHW(S)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    initial clk = 1'b0;
    always #5 clk = ~clk;
    function automatic logic [W-1:0] ref_f(input logic [W-1:0] d, input int n, input logic [2:0] t);
        logic [2*W-1:0] dd;
        case (t)
            3'b000, 3'b010: return d << n;
            3'b001:         return d >> n;
            3'b011:         return W'($signed(d) >>> n);
            3'b100: begin
                dd = {d, d} << n;
                return dd[2*W-1:W];
            end
            3'b101: begin
                dd = {d, d} >> n;
                return dd[W-1:0];
            end
            default:        return d;
        endcase
    endfunction
    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask
    // Drive one cycle at the negedge, update the model at the edge, compare 1 time unit after it.
    task automatic step(input logic rn, input logic v, input logic [W-1:0] d, input logic [S-1:0] a, input logic [2:0] t);
        rst_n         = rn;
        bus.in_valid  = v;
        bus.datain    = d;
        bus.shiftamt  = a;
        bus.shifttype = t;
        @(posedge clk);
        if (!rn) begin
            exp_valid = 1'b0;
            exp_data  = '0;
        end else begin
            exp_valid = v;
            if (v) exp_data = ref_f(d, int'(a), t);
        end
        #1;
        check("out_valid", W'(bus.out_valid), W'(exp_valid));
        check("dataout", bus.dataout, exp_data);
        @(negedge clk);
    endtask
    initial begin
        checks    = 0;
        errors    = 0;
        exp_valid = 1'b0;
        exp_data  = '0;
        tbl.push_back('{8'hE5, 3'd3, 3'b000, 8'h28});
        tbl.push_back('{8'hE5, 3'd3, 3'b001, 8'h1C});
        tbl.push_back('{8'hE5, 3'd3, 3'b010, 8'h28});
        tbl.push_back('{8'hE5, 3'd3, 3'b011, 8'hFC});
        tbl.push_back('{8'hE5, 3'd3, 3'b100, 8'h2F});
        tbl.push_back('{8'hE5, 3'd3, 3'b101, 8'hBC});
        tbl.push_back('{8'hE5, 3'd3, 3'b110, 8'hE5});
        tbl.push_back('{8'hE5, 3'd3, 3'b111, 8'hE5});
        for (int t = 0; t < 8; t++) tbl.push_back('{8'h96, 3'd0, 3'(t), 8'h96});
        tbl.push_back('{8'h65, 3'd3, 3'b011, 8'h0C});
        tbl.push_back('{8'h80, 3'd7, 3'b011, 8'hFF});
        tbl.push_back('{8'h01, 3'd7, 3'b000, 8'h80});
        tbl.push_back('{8'hFF, 3'd7, 3'b000, 8'h80});
        tbl.push_back('{8'hFF, 3'd7, 3'b001, 8'h01});
        tbl.push_back('{8'h01, 3'd1, 3'b101, 8'h80});
        tbl.push_back('{8'h80, 3'd1, 3'b100, 8'h01});
        rst_n         = 1'b0;
        bus.in_valid  = 1'b1;
        bus.datain    = 8'hAA;
        bus.shiftamt  = 3'd1;
        bus.shifttype = 3'b000;
        @(negedge clk);
        step(1'b0, 1'b1, 8'hAA, 3'd1, 3'b000);
        check("reset dataout", bus.dataout, 8'h00);
        step(1'b0, 1'b1, 8'h55, 3'd2, 3'b100);
        check("reset out_valid", W'(bus.out_valid), 8'h00);
        foreach (tbl[i]) begin
            step(1'b1, 1'b1, tbl[i].d, tbl[i].a, tbl[i].t);
            check($sformatf("table[%0d]", i), bus.dataout, tbl[i].e);
        end
        step(1'b1, 1'b1, 8'h3C, 3'd2, 3'b101);
        check("hold op", bus.dataout, 8'h0F);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 8'($urandom), 3'($urandom), 3'($urandom));
            check("hold data", bus.dataout, 8'h0F);
        end
        step(1'b1, 1'b1, 8'hC3, 3'd4, 3'b100);
        step(1'b0, 1'b1, 8'h7E, 3'd1, 3'b000);
        check("midreset data", bus.dataout, 8'h00);
        for (int d = 0; d < 256; d++)
            for (int a = 0; a < 8; a++)
                for (int t = 0; t < 8; t++)
                    step(1'b1, 1'b1, 8'(d), 3'(a), 3'(t));
        for (int i = 0; i < 3000; i++)
            step(($urandom_range(0, 63) != 0), ($urandom_range(0, 3) != 0),
                 8'($urandom), 3'($urandom), 3'($urandom));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
